// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches and buffers
// returned instructions (with their PCs) for decode; redirects flush and drop stale responses.
module if_fetch_unit #(
   parameter int unsigned    PC_W     = 32,
   parameter int unsigned    ADDR_W   = 14,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [PC_W-1:0]   id_pc,
   output logic [31:0]       id_instr
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;
   localparam int unsigned CNT_W = $clog2(2 * DEPTH + 1);

   logic [PC_W-1:0]  pc;
   logic [PC_W-1:0]  slot_pc    [DEPTH];
   logic [31:0]      slot_instr [DEPTH];
   logic [DEPTH-1:0] slot_filled;

   logic [PTR_W-1:0] alloc_ptr, fill_ptr, head_ptr;
   logic [CNT_W-1:0] inflight, stale;

   logic [IDX_W-1:0] alloc_idx, fill_idx, head_idx;
   logic [PTR_W-1:0] occupancy;
   logic             req_fire, rsp_fire, rsp_keep, deq;
   logic [CNT_W-1:0] inflight_next;

   assign alloc_idx = alloc_ptr[IDX_W-1:0];
   assign fill_idx  = fill_ptr[IDX_W-1:0];
   assign head_idx  = head_ptr[IDX_W-1:0];

   // Wrap bits make occupancy == DEPTH distinguishable from empty.
   assign occupancy      = alloc_ptr - head_ptr;
   assign imem_req_valid = !rst && !redirect_valid && (occupancy < PTR_W'(DEPTH));
   assign imem_req_addr  = pc[ADDR_W+1:2];

   assign req_fire = imem_req_valid && imem_req_ready;
   // A response with nothing outstanding is a protocol error and is dropped.
   assign rsp_fire = imem_rsp_valid && (inflight != '0);
   assign rsp_keep = rsp_fire && (stale == '0) && !redirect_valid && !rst;

   assign id_valid = !rst && !redirect_valid && slot_filled[head_idx] && (head_ptr != fill_ptr);
   assign id_pc    = slot_pc[head_idx];
   assign id_instr = slot_instr[head_idx];
   assign deq      = id_valid && id_ready;

   assign inflight_next = inflight + CNT_W'(req_fire) - CNT_W'(rsp_fire);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         alloc_ptr   <= '0;
         fill_ptr    <= '0;
         head_ptr    <= '0;
         inflight    <= '0;
         stale       <= '0;
         slot_filled <= '0;
      end else begin
         inflight <= inflight_next;
         if (redirect_valid) begin
            pc          <= redirect_pc & ~PC_W'(3);
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            slot_filled <= '0;
            stale       <= inflight - CNT_W'(rsp_fire);
         end else begin
            if (req_fire) begin
               pc                     <= pc + PC_W'(4);
               alloc_ptr              <= alloc_ptr + PTR_W'(1);
               slot_filled[alloc_idx] <= 1'b0;
            end
            if (rsp_fire) begin
               if (stale != '0) begin
                  stale <= stale - CNT_W'(1);
               end else begin
                  slot_filled[fill_idx] <= 1'b1;
                  fill_ptr              <= fill_ptr + PTR_W'(1);
               end
            end
            if (deq) begin
               slot_filled[head_idx] <= 1'b0;
               head_ptr              <= head_ptr + PTR_W'(1);
            end
         end
      end
   end

   // NOTE: the slot payload is not reset; a slot is only visible to decode once
   // its filled bit (which is reset) is set, so reset-time contents never leak.
   always_ff @(posedge clk) begin
      if (req_fire) slot_pc[alloc_idx] <= pc;
      if (rsp_keep) slot_instr[fill_idx] <= imem_rsp_data;
   end

   a_rsp_needs_request: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (inflight != '0));

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Parametrised next-generation instruction-fetch stage. Owns the PC and issues word-aligned fetch requests to instruction memory over a valid/ready request channel with variable-latency, in-order responses.
- Buffers up to DEPTH fetched instructions together with their PCs, and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirect: flushes buffered entries and silently discards responses to requests already in flight.

Parameters:
- PC_W, 32, PC width in bits.
- ADDR_W, 14, instruction-memory word-address width; imem_req_addr = pc[ADDR_W+1:2].
- DEPTH, 4, number of fetch-buffer slots (power of 2, ≥2); also the maximum number of outstanding non-stale requests.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk input 1 — clock, rising edge.
- rst input 1 — synchronous, active-high reset.
- redirect_valid input 1 — branch/jump taken; load redirect_pc and flush.
- redirect_pc input PC_W — redirect target; bits [1:0] ignored (treated as 0).
- imem_req_valid output 1 — fetch request valid.
- imem_req_ready input 1 — memory accepts the request.
- imem_req_addr output ADDR_W — word address of the request.
- imem_rsp_valid input 1 — response valid; responses return in request order, 1 or more cycles after acceptance.
- imem_rsp_data input 32 — instruction word.
- id_valid output 1 — head slot holds a filled instruction.
- id_ready input 1 — decode consumes the head (0 = stall).
- id_pc output PC_W — PC of the head instruction.
- id_instr output 32 — head instruction.

Behaviour:
- State:
  - pc register.
  - DEPTH slots of {pc, instr, filled}.
  - Pointers alloc_ptr, fill_ptr, head_ptr, each log2(DEPTH)+1 bits with a wrap bit.
  - inflight counter (0..2·DEPTH).
  - stale counter (0..2·DEPTH).
- Reset (rst=1 at an edge): pc=RESET_PC; all pointers, inflight and stale = 0; all filled bits = 0.
- While rst=1, imem_req_valid=0 and id_valid=0. Reset mid-transaction abandons in-flight responses; the memory side is reset by the same rst.
- Issue:
  - imem_req_valid = !rst && !redirect_valid && (alloc_ptr − head_ptr < DEPTH).
  - req_fire = imem_req_valid && imem_req_ready.
  - On req_fire: slot[alloc].pc ← pc, slot[alloc].filled ← 0, alloc_ptr++, pc ← pc+4 (wraps modulo 2^PC_W).
  - imem_req_addr = pc[ADDR_W+1:2]; it is combinational and held stable while valid && !ready.
- Response (rsp_fire = imem_rsp_valid):
  - If stale>0: discard the data and decrement stale.
  - Otherwise: slot[fill].instr ← data, filled ← 1, fill_ptr++.
  - inflight = inflight + req_fire − rsp_fire every cycle.
  - A response with inflight=0 is a protocol error; it is ignored and flagged by an assertion.
- Dequeue:
  - id_valid = slot[head].filled && head_ptr ≠ fill_ptr && !redirect_valid.
  - On id_valid && id_ready: clear filled, head_ptr++.
  - id_pc and id_instr come from slot[head] and stay stable while id_valid && !id_ready.
- Fetch-to-decode latency: a response in cycle N makes id_valid=1 in cycle N+1. The minimum end-to-end time is request accept in cycle 0 → id_valid in cycle 2 with 1-cycle memory.
- Redirect (redirect_valid=1 at an edge), which has priority over all other updates:
  - pc ← {redirect_pc[PC_W-1:2], 2'b00}.
  - All pointers ← 0; all filled ← 0.
  - stale ← inflight − rsp_fire_this_cycle. Any response arriving in the redirect cycle is discarded; no request fires in the redirect cycle.
  - No dequeue occurs in the redirect cycle.
  - Back-to-back redirects: the last one wins, and stale is recomputed each time.
- Full: when alloc_ptr − head_ptr == DEPTH, no issue occurs. Issue resumes in the cycle after a dequeue.
- Simultaneous events: issue, fill and dequeue are all allowed in the same cycle.
  - Pop and allocate of the same physical slot cannot collide, because full blocks issue.
- Empty: id_valid=0. Decode sees a bubble, never stale data.

Test Plan:
- Reset, RESET_PC=0, memory 1-cycle, id_ready=1 → requests to addr 0,1,2,…; id_pc sequence 0x0,0x4,0x8,… with matching instructions; first id_valid 2 cycles after the first accept.
- id_ready=0 for 10 cycles with DEPTH=4 → exactly 4 requests accepted, then imem_req_valid stays 0. id_pc=0x0 is held stable. Releasing id_ready drains the 4 slots in order, and issue restarts.
- 3-cycle memory latency with 3 requests in flight, then redirect_pc=0x102 → next request addr=0x40 (pc 0x100). The 3 old responses are dropped, and the first id_pc after the redirect is 0x100.
- Redirect in the same cycle as a response, plus a second redirect 1 cycle later to 0x200 → no pre-redirect instruction reaches decode; first id_pc=0x200.
- imem_req_ready toggled randomly → imem_req_addr stable while unaccepted; no duplicated or skipped PCs; PC wraps from 0xFFFF_FFFC to 0x0.
- rst asserted with 2 requests in flight → after reset: pc=RESET_PC, id_valid=0, inflight=0, stale=0.
